multi_port_mem_ctrl: RTL and testbench
======================================

MULTI_PORT_MEM_CTRL -- requirements
Module: multi_port_mem_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (legal 2..8).
REQ-002 SHALL have parameter IO_HI, default 2'b11, value of addr[17:16] that marks the I/O region.
REQ-003 SHALL be built on one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global enable; freeze when low
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full
- req_valid  in  NUM_CH  per-channel request
- req_addr  in  32*NUM_CH  start byte address
- req_wdata  in  32*NUM_CH  store data, little-endian
- req_wr  in  NUM_CH  1 = store
- req_size  in  2*NUM_CH  00 byte, 01 half, 10/11 word
- req_signed  in  NUM_CH  sign-extend load result
- flush_in  in  NUM_CH  per-channel abort
- req_ready  out  NUM_CH  one-hot grant
- resp_valid  out  NUM_CH  one-hot completion pulse
- resp_data  out  32  load result, shared

Function
REQ-005 SHALL use states IDLE, XFER, LAST (read tail), STALL (I/O wait), RESP.
REQ-006 IDLE: req_ready SHALL be combinational, one-hot, to the round-robin winner among req_valid & ~flush_in; handshake = req_valid & req_ready at a rising edge (cycle C0).
REQ-007 Round-robin: after granting channel k, priority SHALL start at (k+1) mod NUM_CH; after reset, channel 0 has priority.
REQ-008 On handshake, addr/wdata/wr/size/signed and the channel id SHALL be latched; n = 1, 2 or 4 bytes.
REQ-009 XFER cycles C1..Cn: mem_a SHALL equal addr+j (32-bit wrap) for byte j; on store, mem_wr=1 and mem_dout=wdata[8j+7:8j].
REQ-010 Load: byte j SHALL be sampled from mem_din in the cycle after it is addressed; LAST captures byte n-1; RESP cycle C(n+2) asserts resp_valid[ch] with zero/sign-extended resp_data.
REQ-011 Store: RESP SHALL occur in cycle C(n+1); resp_data = 0.
REQ-012 RESP lasts exactly one cycle, then IDLE; req_ready SHALL be 0 outside IDLE.
REQ-013 Outside XFER: mem_wr=0, mem_a=0, mem_dout=0.
REQ-014 rdy_in low SHALL freeze all state, counters and the RR pointer; mem_wr forced 0, req_ready and resp_valid forced 0; a pending mem_din byte SHALL be sampled in the first rdy_in-high cycle.
REQ-015 flush_in[ch] on an in-flight load SHALL return to IDLE next edge with no resp_valid; an in-flight store SHALL complete and still pulse resp_valid.
REQ-016 Simultaneous flush_in and req_valid on one channel: no grant to that channel that cycle.

Reset
REQ-017 While rst_n_in low: state IDLE, RR pointer 0, all outputs 0, latched request cleared, independent of clk_in and rdy_in.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer; no resp_valid after release.

Configuration
REQ-019 Macro MPMC_IO_STALL_EN: defined -> a store whose addr[17:16]==IO_HI SHALL enter STALL before each byte while io_buffer_full=1 (mem_wr=0) and resume the cycle after it drops; undefined -> io_buffer_full ignored, STALL unreachable.

Verification
REQ-020 ch0 LW addr 0x100, RAM 0x100..0x103 = 78 56 34 12 -> mem_a 0x100..0x103 in C1..C4, resp_valid[0] in C6, resp_data 0x12345678.
REQ-021 ch1 LB signed at 0x20, byte 0x80 -> resp_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-022 ch0 and ch1 valid every cycle -> grants alternate 0,1,0,1; no channel granted twice consecutively.
REQ-023 SB 0x41 to 0x30000, io_buffer_full high 5 cycles (macro defined) -> mem_wr=0 for those cycles, one write of 0x41 after, resp_valid once.
REQ-024 LW in flight, rdy_in low 3 cycles at C2 -> mem_a held, result unchanged, resp_valid delayed exactly 3 cycles; flush_in at C3 of a load -> no resp_valid, IDLE next cycle.

Source files
------------

// File: rtl/multi_port_mem_ctrl_if.sv
// rtl/multi_port_mem_ctrl_if.sv - request/response and byte-RAM bus bundle for multi_port_mem_ctrl
//
// Purpose: groups every non-clock/reset signal of multi_port_mem_ctrl.
// Ports (slave = controller view):
//   rdy_in, io_buffer_full          global enable / UART buffer full
//   mem_din / mem_dout, mem_a, mem_wr   byte-wide RAM port
//   req_valid, req_addr, req_wdata, req_wr, req_size, req_signed, flush_in
//                                   per-channel requests (packed, channel k at slice k)
//   req_ready, resp_valid           one-hot grant / completion pulse
//   resp_data                       shared load result
interface multi_port_mem_ctrl_if #(
    parameter int NUM_CH = 2
);
    logic                  rdy_in;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [31:0]           mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;
    logic [NUM_CH-1:0]     req_valid;
    logic [32*NUM_CH-1:0]  req_addr;
    logic [32*NUM_CH-1:0]  req_wdata;
    logic [NUM_CH-1:0]     req_wr;
    logic [2*NUM_CH-1:0]   req_size;
    logic [NUM_CH-1:0]     req_signed;
    logic [NUM_CH-1:0]     flush_in;
    logic [NUM_CH-1:0]     req_ready;
    logic [NUM_CH-1:0]     resp_valid;
    logic [31:0]           resp_data;

    modport slave (
        input  rdy_in, mem_din, io_buffer_full, req_valid, req_addr, req_wdata,
               req_wr, req_size, req_signed, flush_in,
        output mem_dout, mem_a, mem_wr, req_ready, resp_valid, resp_data
    );

    modport master (
        output rdy_in, mem_din, io_buffer_full, req_valid, req_addr, req_wdata,
               req_wr, req_size, req_signed, flush_in,
        input  mem_dout, mem_a, mem_wr, req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/multi_port_mem_ctrl.sv
// rtl/multi_port_mem_ctrl.sv - round-robin multi-channel byte-serial memory controller
//
// Purpose: arbitrates NUM_CH load/store requesters onto a byte-wide synchronous
// RAM, serialising 1/2/4-byte accesses and returning zero/sign-extended loads.
// Ports:
//   clk_in    system clock
//   rst_n_in  asynchronous active-low reset
//   bus       multi_port_mem_ctrl_if.slave (RAM port, request/response channels)
// Optional feature: define MPMC_IO_STALL_EN to make stores into the I/O region
// (addr[17:16] == IO_HI) wait in STALL while io_buffer_full is high.
module multi_port_mem_ctrl #(
    parameter int         NUM_CH = 2,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    multi_port_mem_ctrl_if.slave  bus
);
    localparam int CW  = $clog2(NUM_CH);
    localparam int CW1 = CW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_XFER  = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_STALL = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] rr_q, rr_d, ch_q, ch_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic          wr_q, wr_d, sgn_q, sgn_d;
    logic [1:0]    size_q, size_d, cnt_q, cnt_d;

    // Round-robin search starting at rr_q; a channel being flushed is never eligible.
    logic [NUM_CH-1:0] elig, grant;
    logic [CW-1:0]     win;
    logic [CW:0]       pick;
    logic              found;

    always_comb begin
        elig  = bus.req_valid & ~bus.flush_in;
        grant = '0;
        win   = '0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pick = {1'b0, rr_q} + CW1'(k);
            if (pick >= CW1'(NUM_CH)) pick = pick - CW1'(NUM_CH);
            if (!found && elig[pick[CW-1:0]]) begin
                found = 1'b1;
                win   = pick[CW-1:0];
            end
        end
        if (found) grant[win] = 1'b1;
    end

    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_wr, sel_sgn;
    assign sel_addr  = bus.req_addr[32*win +: 32];
    assign sel_wdata = bus.req_wdata[32*win +: 32];
    assign sel_size  = bus.req_size[2*win +: 2];
    assign sel_wr    = bus.req_wr[win];
    assign sel_sgn   = bus.req_signed[win];

    logic [1:0] last_idx;
    assign last_idx = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;

    // Only loads can be aborted; a store already on the bus runs to completion.
    logic flush_cur;
    assign flush_cur = bus.flush_in[ch_q] && !wr_q;

    // stall_new: decision for the first byte (taken in IDLE from the live request);
    // stall_cur: decision before each following byte.
    logic stall_new, stall_cur;
`ifdef MPMC_IO_STALL_EN
    assign stall_new = sel_wr && (sel_addr[17:16] == IO_HI) && bus.io_buffer_full;
    assign stall_cur = wr_q && (addr_q[17:16] == IO_HI) && bus.io_buffer_full;
`else
    logic unused_io_hi;
    assign stall_new    = 1'b0;
    assign stall_cur    = 1'b0;
    assign unused_io_hi = (IO_HI == 2'b00);
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        sgn_d   = sgn_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        if (bus.rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        ch_d    = win;
                        rr_d    = (win == CW'(NUM_CH - 1)) ? '0 : win + 1'b1;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        wr_d    = sel_wr;
                        sgn_d   = sel_sgn;
                        size_d  = sel_size;
                        cnt_d   = 2'd0;
                        rdata_d = '0;
                        state_d = stall_new ? S_STALL : S_XFER;
                    end
                end
                S_XFER: begin
                    if (flush_cur) begin
                        state_d = S_IDLE;
                    end else begin
                        // RAM read data lags its address by one cycle.
                        if (!wr_q && cnt_q != 2'd0) rdata_d[8*(cnt_q - 2'd1) +: 8] = bus.mem_din;
                        if (cnt_q == last_idx) begin
                            state_d = wr_q ? S_RESP : S_LAST;
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = stall_cur ? S_STALL : S_XFER;
                        end
                    end
                end
                S_LAST: begin
                    if (flush_cur) begin
                        state_d = S_IDLE;
                    end else begin
                        rdata_d[8*last_idx +: 8] = bus.mem_din;
                        state_d = S_RESP;
                    end
                end
                S_STALL: if (!bus.io_buffer_full) state_d = S_XFER;
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 2'b00;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            sgn_q   <= sgn_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    logic in_xfer, resp_fire;
    assign in_xfer   = (state_q == S_XFER);
    assign resp_fire = (state_q == S_RESP) && bus.rdy_in && rst_n_in && !flush_cur;

    // mem_a deliberately keeps its value while rdy_in is low so the RAM address is held.
    assign bus.mem_a      = in_xfer ? addr_q + {30'd0, cnt_q} : 32'd0;
    assign bus.mem_wr     = in_xfer && wr_q && bus.rdy_in;
    assign bus.mem_dout   = (in_xfer && wr_q) ? wdata_q[8*cnt_q +: 8] : 8'd0;
    assign bus.req_ready  = ((state_q == S_IDLE) && bus.rdy_in && rst_n_in) ? grant : '0;
    assign bus.resp_valid = resp_fire ? (NUM_CH'(1) << ch_q) : '0;

    logic [31:0] resp_ext;
    always_comb begin
        resp_ext = 32'd0;
        if (state_q == S_RESP && !wr_q) begin
            case (size_q)
                2'b00:   resp_ext = {{24{sgn_q & rdata_q[7]}}, rdata_q[7:0]};
                2'b01:   resp_ext = {{16{sgn_q & rdata_q[15]}}, rdata_q[15:0]};
                default: resp_ext = rdata_q;
            endcase
        end
    end
    assign bus.resp_data = resp_ext;
endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// tb/tb_multi_port_mem_ctrl.sv - self-checking bench for multi_port_mem_ctrl
module tb_multi_port_mem_ctrl;
    localparam int N = 2;

    logic clk_in = 1'b0;
    logic rst_n_in;
    always #5 clk_in = ~clk_in;

    multi_port_mem_ctrl_if #(.NUM_CH(N)) bus ();

    multi_port_mem_ctrl #(.NUM_CH(N), .IO_HI(2'b11)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus.slave)
    );

    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:4095];
    int          wr_count = 0;
    logic [31:0] last_wa;
    logic [7:0]  last_wd;

    // Byte RAM with one-cycle read latency; it shares the global enable.
    always @(posedge clk_in) begin
        if (bus.rdy_in) begin
            bus.mem_din <= ram[bus.mem_a[11:0]];
            if (bus.mem_wr) begin
                ram[bus.mem_a[11:0]] = bus.mem_dout;
                wr_count++;
                last_wa = bus.mem_a;
                last_wd = bus.mem_dout;
            end
        end
    end

    int passed = 0;
    int total  = 0;
    int prio   = 0;
    bit flush_during = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    function automatic int rr_pick(input logic [N-1:0] el);
        for (int k = 0; k < N; k++) begin
            int c = (prio + k) % N;
            if (el[c]) return c;
        end
        return -1;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n;
        longint v;
        logic [31:0] ab;
        n = nbytes(sz);
        v = 0;
        for (int j = 0; j < n; j++) begin
            ab = a + 32'(j);
            v = v + (longint'(shadow[ab[11:0]]) << (8 * j));
        end
        if (sg && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic set_req(input int ch, input logic [31:0] a, input logic [1:0] sz,
                           input logic w, input logic sg, input logic [31:0] wd);
        bus.req_addr[32*ch +: 32]  = a;
        bus.req_wdata[32*ch +: 32] = wd;
        bus.req_size[2*ch +: 2]    = sz;
        bus.req_wr[ch]             = w;
        bus.req_signed[ch]         = sg;
    endtask

    task automatic grant_only(input int ch);
        int e;
        bus.req_valid = N'(1) << ch;
        #1;
        e = rr_pick(bus.req_valid);
        check("grant", 32'(bus.req_ready), 32'(1) << e);
        prio = (e + 1) % N;
    endtask

    task automatic run_txn(input int ch, input logic [31:0] a, input logic [1:0] sz,
                           input logic w, input logic sg, input logic [31:0] wd);
        int n;
        logic [31:0] ed, ab;
        n  = nbytes(sz);
        ed = w ? 32'd0 : exp_load(a, sz, sg);
        set_req(ch, a, sz, w, sg, wd);
        grant_only(ch);
        tick();
        bus.req_valid = '0;
        if (flush_during) bus.flush_in = N'(1) << ch;
        #1;
        for (int j = 0; j < n; j++) begin
            ab = a + 32'(j);
            check("xfer_mem_a", bus.mem_a, ab);
            check("xfer_mem_wr", 32'(bus.mem_wr), 32'(w));
            if (w) check("xfer_dout", 32'(bus.mem_dout), (wd >> (8 * j)) & 32'hFF);
            check("xfer_resp", 32'(bus.resp_valid), 32'd0);
            tick();
            #1;
        end
        if (!w) begin
            check("last_mem_a", bus.mem_a, 32'd0);
            check("last_resp", 32'(bus.resp_valid), 32'd0);
            tick();
            #1;
        end
        check("resp_valid", 32'(bus.resp_valid), 32'(1) << ch);
        check("resp_data", bus.resp_data, ed);
        tick();
        bus.flush_in = '0;
        #1;
        check("resp_once", 32'(bus.resp_valid), 32'd0);
        if (w) begin
            for (int j = 0; j < n; j++) begin
                ab = a + 32'(j);
                shadow[ab[11:0]] = wd[8*j +: 8];
                check("ram_store", 32'(ram[ab[11:0]]), 32'(shadow[ab[11:0]]));
            end
        end
    endtask

    int          e, k, cnt, wc0, wr_full, resp_cnt;
    logic [N-1:0] prev_grant;
    logic [31:0] exp_a;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = 8'($urandom);
            shadow[i] = ram[i];
        end
        ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        ram[12'h020] = 8'h80;
        for (int i = 12'h100; i < 12'h104; i++) shadow[i] = ram[i];
        shadow[12'h020] = 8'h80;

        rst_n_in = 1'b0;
        bus.rdy_in = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus.req_valid = '1;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_wr = '0;
        bus.req_size = '0; bus.req_signed = '0; bus.flush_in = '0;

        // Reset: all outputs quiet even with requests pending.
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        tick(); tick();
        check("rst_ready2", 32'(bus.req_ready), 32'd0);
        check("rst_resp", 32'(bus.resp_valid), 32'd0);
        check("rst_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_data", bus.resp_data, 32'd0);
        rst_n_in = 1'b1;
        bus.req_valid = '0;
        prio = 0;

        // Directed loads.
        run_txn(0, 32'h100, 2'b10, 1'b0, 1'b0, 32'd0);
        check("lw_value", exp_load(32'h100, 2'b10, 1'b0), 32'h12345678);
        run_txn(1, 32'h20, 2'b00, 1'b0, 1'b1, 32'd0);
        run_txn(1, 32'h20, 2'b00, 1'b0, 1'b0, 32'd0);
        check("lb_signed_model", exp_load(32'h20, 2'b00, 1'b1), 32'hFFFFFF80);

        // Randomised traffic, one channel at a time, away from the directed bytes.
        for (int t = 0; t < 24; t++) begin
            run_txn($urandom_range(0, N - 1), 32'($urandom_range(12'h400, 12'hF00)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
        end

        // Both channels requesting continuously: grants follow the rotating priority.
        set_req(0, 32'h100, 2'b10, 1'b0, 1'b0, 32'd0);
        set_req(1, 32'h200, 2'b10, 1'b0, 1'b0, 32'd0);
        bus.req_valid = 2'b11;
        prev_grant = '0;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            #1;
            while (bus.req_ready == '0 && k < 30) begin
                tick();
                #1;
                k++;
            end
            check("rr_wait", 32'(k < 30), 32'd1);
            e = rr_pick(2'b11);
            check("rr_grant", 32'(bus.req_ready), 32'(1) << e);
            check("rr_no_repeat", 32'(bus.req_ready != prev_grant), 32'd1);
            prev_grant = bus.req_ready;
            prio = (e + 1) % N;
            tick();
            if (g == 3) bus.req_valid = '0;
        end
        repeat (8) tick();

        // Flush and valid together on one channel blocks only that channel.
        bus.req_valid = 2'b11;
        bus.flush_in = 2'b01; #1;
        check("flush_blk0", 32'(bus.req_ready), 32'b10);
        bus.flush_in = 2'b10; #1;
        check("flush_blk1", 32'(bus.req_ready), 32'b01);
        bus.flush_in = 2'b11; #1;
        check("flush_blk_all", 32'(bus.req_ready), 32'd0);
        bus.flush_in = '0;
        bus.rdy_in = 1'b0; #1;
        check("frz_idle_ready", 32'(bus.req_ready), 32'd0);
        bus.rdy_in = 1'b1;
        bus.req_valid = '0;

        // rdy_in low for C2..C4 of a word load delays everything by three cycles.
        set_req(0, 32'h100, 2'b10, 1'b0, 1'b0, 32'd0);
        grant_only(0);
        tick();
        bus.req_valid = '0;
        for (int c = 1; c <= 10; c++) begin
            bus.rdy_in = !(c >= 2 && c <= 4);
            #1;
            exp_a = (c == 1) ? 32'h100 : (c <= 5) ? 32'h101 : (c == 6) ? 32'h102 :
                    (c == 7) ? 32'h103 : 32'h0;
            check("frz_mem_a", bus.mem_a, exp_a);
            check("frz_resp", 32'(bus.resp_valid), (c == 9) ? 32'd1 : 32'd0);
            if (c == 9) check("frz_data", bus.resp_data, 32'h12345678);
            tick();
        end
        bus.rdy_in = 1'b1;

        // Flush at C3 of a load: back to IDLE next cycle, never a response.
        set_req(1, 32'h100, 2'b10, 1'b0, 1'b0, 32'd0);
        grant_only(1);
        tick(); bus.req_valid = '0;
        tick(); tick();
        bus.flush_in = 2'b10;
        tick();
        bus.flush_in = '0;
        #1;
        check("flush_mem_a", bus.mem_a, 32'd0);
        bus.req_valid = 2'b01; #1;
        check("flush_idle", 32'(bus.req_ready), 32'b01);
        bus.req_valid = '0;
        cnt = 0;
        repeat (6) begin
            tick(); #1;
            if (bus.resp_valid != '0) cnt++;
        end
        check("flush_no_resp", 32'(cnt), 32'd0);

        // Flush held over a store does not stop it.
        flush_during = 1'b1;
        run_txn(0, 32'h500, 2'b10, 1'b1, 1'b0, $urandom);
        flush_during = 1'b0;

        // Byte store into the I/O region with the UART buffer full for five cycles.
        set_req(0, 32'h30000, 2'b00, 1'b1, 1'b0, 32'h41);
        bus.io_buffer_full = 1'b1;
        wc0 = wr_count;
        grant_only(0);
        tick();
        bus.req_valid = '0;
        wr_full = 0;
        resp_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            bus.io_buffer_full = (c < 5);
            #1;
            if (bus.io_buffer_full && bus.mem_wr) wr_full++;
            if (bus.resp_valid[0]) resp_cnt++;
            tick();
        end
`ifdef MPMC_IO_STALL_EN
        check("io_no_wr_full", 32'(wr_full), 32'd0);
`endif
        check("io_wr_count", 32'(wr_count - wc0), 32'd1);
        check("io_wr_addr", last_wa, 32'h30000);
        check("io_wr_data", 32'(last_wd), 32'h41);
        check("io_resp_once", 32'(resp_cnt), 32'd1);
        shadow[12'h000] = 8'h41;

        // Reset in the middle of a load abandons it and restarts arbitration at channel 0.
        set_req(1, 32'h100, 2'b10, 1'b0, 1'b0, 32'd0);
        grant_only(1);
        tick(); bus.req_valid = '0;
        tick();
        rst_n_in = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check("mrst_mem_a", bus.mem_a, 32'd0);
        check("mrst_ready", 32'(bus.req_ready), 32'd0);
        check("mrst_resp", 32'(bus.resp_valid), 32'd0);
        tick(); tick();
        rst_n_in = 1'b1;
        bus.req_valid = '0;
        prio = 0;
        cnt = 0;
        repeat (8) begin
            tick(); #1;
            if (bus.resp_valid != '0) cnt++;
        end
        check("mrst_no_resp", 32'(cnt), 32'd0);
        bus.req_valid = 2'b11; #1;
        e = rr_pick(2'b11);
        check("mrst_rr", 32'(bus.req_ready), 32'(1) << e);
        bus.req_valid = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
